// File: rtl/rs_array.sv
`default_nettype none
// ============================================================================
// Module      : rs_array
// Description : Tomasulo reservation-station array with CDB operand capture,
//               issue-time forwarding and lowest-index-first dispatch.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_array #(
    parameter int DEPTH    = 3,
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 5,
    parameter int OP_W     = 4,
    parameter int TAG_BASE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [OP_W-1:0]            issue_op,
    input  logic [TAG_W-1:0]           issue_qj,
    input  logic [DATA_W-1:0]          issue_vj,
    input  logic [TAG_W-1:0]           issue_qk,
    input  logic [DATA_W-1:0]          issue_vk,
    output logic [TAG_W-1:0]           issue_tag,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [DATA_W-1:0]          cdb_data,
    output logic                       disp_valid,
    input  logic                       disp_ready,
    output logic [OP_W-1:0]            disp_op,
    output logic [DATA_W-1:0]          disp_vj,
    output logic [DATA_W-1:0]          disp_vk,
    output logic [TAG_W-1:0]           disp_tag,
    output logic [DEPTH-1:0]           busy_vec,
    output logic [$clog2(DEPTH+1)-1:0] free_cnt
);

    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  r_busy;
    logic [OP_W-1:0]   r_op [DEPTH];
    logic [TAG_W-1:0]  r_qj [DEPTH];
    logic [TAG_W-1:0]  r_qk [DEPTH];
    logic [DATA_W-1:0] r_vj [DEPTH];
    logic [DATA_W-1:0] r_vk [DEPTH];

    logic [DEPTH-1:0]   w_ready;
    logic [DEPTH-1:0]   w_cap_j;
    logic [DEPTH-1:0]   w_cap_k;
    logic               w_free_found;
    logic [c_IDX_W-1:0] w_free_idx;
    logic               w_disp_found;
    logic [c_IDX_W-1:0] w_disp_idx;
    logic [c_CNT_W-1:0] w_free_cnt;
    logic               w_issue_fire;
    logic               w_disp_fire;
    logic               w_fwd_j;
    logic               w_fwd_k;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign w_ready[gi] = r_busy[gi] && (r_qj[gi] == '0) && (r_qk[gi] == '0);
        assign w_cap_j[gi] = cdb_valid && r_busy[gi] && (r_qj[gi] != '0) && (r_qj[gi] == cdb_tag);
        assign w_cap_k[gi] = cdb_valid && r_busy[gi] && (r_qk[gi] != '0) && (r_qk[gi] == cdb_tag);
    end

    // Descending scans so the lowest matching index is the one left standing.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_disp_found = 1'b0;
        w_disp_idx   = '0;
        w_free_cnt   = c_CNT_W'(DEPTH);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_disp_found = 1'b1;
                w_disp_idx   = c_IDX_W'(i);
            end
            if (r_busy[i]) begin
                w_free_cnt = w_free_cnt - c_CNT_W'(1);
            end
        end
    end

    assign w_issue_fire = issue_valid && w_free_found && !flush;
    assign w_disp_fire  = w_disp_found && disp_ready && !flush;
    assign w_fwd_j      = cdb_valid && (issue_qj != '0) && (issue_qj == cdb_tag);
    assign w_fwd_k      = cdb_valid && (issue_qk != '0) && (issue_qk == cdb_tag);

    // The issue target was free before the edge, so it never collides with
    // the dispatch target or with a CDB capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_op[i] <= '0;
                r_qj[i] <= '0;
                r_qk[i] <= '0;
                r_vj[i] <= '0;
                r_vk[i] <= '0;
            end
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_issue_fire && (w_free_idx == c_IDX_W'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_op[i]   <= issue_op;
                    r_qj[i]   <= w_fwd_j ? '0 : issue_qj;
                    r_vj[i]   <= w_fwd_j ? cdb_data : issue_vj;
                    r_qk[i]   <= w_fwd_k ? '0 : issue_qk;
                    r_vk[i]   <= w_fwd_k ? cdb_data : issue_vk;
                end else begin
                    if (w_disp_fire && (w_disp_idx == c_IDX_W'(i))) begin
                        r_busy[i] <= 1'b0;
                    end
                    if (w_cap_j[i]) begin
                        r_qj[i] <= '0;
                        r_vj[i] <= cdb_data;
                    end
                    if (w_cap_k[i]) begin
                        r_qk[i] <= '0;
                        r_vk[i] <= cdb_data;
                    end
                end
            end
        end
    end

    assign issue_ready = w_free_found;
    assign issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(w_free_idx);
    assign disp_valid  = w_disp_found;
    assign disp_op     = w_disp_found ? r_op[w_disp_idx] : '0;
    assign disp_vj     = w_disp_found ? r_vj[w_disp_idx] : '0;
    assign disp_vk     = w_disp_found ? r_vk[w_disp_idx] : '0;
    assign disp_tag    = w_disp_found ? (TAG_W'(TAG_BASE) + TAG_W'(w_disp_idx)) : '0;
    assign busy_vec    = r_busy;
    assign free_cnt    = w_free_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rs_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_array
// Description : Directed scenarios plus randomized traffic against a
//               behavioural station model for rs_array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [3:0]  issue_op = '0;
    logic [4:0]  issue_qj = '0;
    logic [31:0] issue_vj = '0;
    logic [4:0]  issue_qk = '0;
    logic [31:0] issue_vk = '0;
    logic [4:0]  issue_tag;
    logic        cdb_valid = 1'b0;
    logic [4:0]  cdb_tag = '0;
    logic [31:0] cdb_data = '0;
    logic        disp_valid;
    logic        disp_ready = 1'b0;
    logic [3:0]  disp_op;
    logic [31:0] disp_vj;
    logic [31:0] disp_vk;
    logic [4:0]  disp_tag;
    logic [2:0]  busy_vec;
    logic [1:0]  free_cnt;

    int total = 0;
    int bad   = 0;

    rs_array #(.DEPTH(3), .DATA_W(32), .TAG_W(5), .OP_W(4), .TAG_BASE(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
        .issue_qj(issue_qj), .issue_vj(issue_vj), .issue_qk(issue_qk), .issue_vk(issue_vk),
        .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_tag(disp_tag),
        .busy_vec(busy_vec), .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        busy;
        bit [3:0]  op;
        bit [4:0]  qj;
        bit [31:0] vj;
        bit [4:0]  qk;
        bit [31:0] vk;
    } ent_t;

    ent_t m [3];
    ent_t mn [3];

    function automatic int first_free();
        for (int i = 0; i < 3; i++) if (!m[i].busy) return i;
        return -1;
    endfunction

    function automatic int first_ready();
        for (int i = 0; i < 3; i++) if (m[i].busy && m[i].qj == 0 && m[i].qk == 0) return i;
        return -1;
    endfunction

    function automatic int n_free();
        int n = 0;
        for (int i = 0; i < 3; i++) if (!m[i].busy) n++;
        return n;
    endfunction

    function automatic bit [2:0] busy_bits();
        bit [2:0] b;
        for (int i = 0; i < 3; i++) b[i] = m[i].busy;
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 0, 0};
    endtask

    // Next state of the station from the inputs currently applied.
    task automatic model_next();
        int ff;
        int rr;
        for (int i = 0; i < 3; i++) mn[i] = m[i];
        if (flush) begin
            for (int i = 0; i < 3; i++) mn[i].busy = 0;
        end else begin
            ff = first_free();
            rr = first_ready();
            if (cdb_valid && cdb_tag != 0) begin
                for (int i = 0; i < 3; i++) begin
                    if (m[i].busy && m[i].qj == cdb_tag) begin mn[i].qj = 0; mn[i].vj = cdb_data; end
                    if (m[i].busy && m[i].qk == cdb_tag) begin mn[i].qk = 0; mn[i].vk = cdb_data; end
                end
            end
            if (rr >= 0 && disp_ready) mn[rr].busy = 0;
            if (issue_valid && ff >= 0) begin
                mn[ff].busy = 1;
                mn[ff].op   = issue_op;
                mn[ff].qj   = issue_qj;
                mn[ff].vj   = issue_vj;
                mn[ff].qk   = issue_qk;
                mn[ff].vk   = issue_vk;
                if (cdb_valid && issue_qj != 0 && issue_qj == cdb_tag) begin mn[ff].qj = 0; mn[ff].vj = cdb_data; end
                if (cdb_valid && issue_qk != 0 && issue_qk == cdb_tag) begin mn[ff].qk = 0; mn[ff].vk = cdb_data; end
            end
        end
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        for (int i = 0; i < 3; i++) m[i] = mn[i];
        @(negedge clk);
    endtask

    task automatic idle();
        flush = 0; issue_valid = 0; issue_op = 0; issue_qj = 0; issue_vj = 0;
        issue_qk = 0; issue_vk = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    endtask

    task automatic drive_issue(input bit [3:0] op, input bit [4:0] qj, input bit [31:0] vj,
                               input bit [4:0] qk, input bit [31:0] vk);
        issue_valid = 1; issue_op = op; issue_qj = qj; issue_vj = vj; issue_qk = qk; issue_vk = vk;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle(); disp_ready = 0; rst_n = 0; model_clear();
        #1;
        total++; if (busy_vec !== 3'b000) begin bad++; $display("FAIL reset_busy: got %b want 000", busy_vec); end
        total++; if (free_cnt !== 2'd3) begin bad++; $display("FAIL reset_free: got %0d want 3", free_cnt); end
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
        total++; if (issue_tag !== 5'd1) begin bad++; $display("FAIL reset_tag: got %0d want 1", issue_tag); end
        total++; if ({disp_valid, disp_tag, disp_op, disp_vj, disp_vk} !== '0) begin
            bad++; $display("FAIL reset_disp: got v=%b tag=%0d op=%0d vj=%0h vk=%0h want all 0",
                            disp_valid, disp_tag, disp_op, disp_vj, disp_vk);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
        total++; if (busy_vec !== 3'b000 || disp_valid !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: got busy=%b dv=%b want 000/0", busy_vec, disp_valid);
        end
    endtask

    task automatic test_single_issue();
        disp_ready = 0;
        drive_issue(4'd2, 5'd0, 32'd5, 5'd0, 32'd7);
        tick();
        idle(); disp_ready = 1; #1;
        total++; if (busy_vec !== 3'b001) begin bad++; $display("FAIL single_busy: got %b want 001", busy_vec); end
        total++; if (disp_valid !== 1'b1 || disp_tag !== 5'd1 || disp_op !== 4'd2) begin
            bad++; $display("FAIL single_disp: got v=%b tag=%0d op=%0d want 1/1/2", disp_valid, disp_tag, disp_op);
        end
        total++; if (disp_vj !== 32'd5 || disp_vk !== 32'd7) begin
            bad++; $display("FAIL single_ops: got vj=%0d vk=%0d want 5/7", disp_vj, disp_vk);
        end
        tick();
        total++; if (busy_vec !== 3'b000) begin bad++; $display("FAIL single_clear: got %b want 000", busy_vec); end
    endtask

    task automatic test_fill_and_capture();
        disp_ready = 1;
        for (int k = 0; k < 3; k++) begin
            drive_issue(4'(k + 1), 5'd9, 32'd0, 5'd0, 32'(k + 10));
            #1;
            total++; if (issue_tag !== 5'(k + 1)) begin bad++; $display("FAIL fill_tag%0d: got %0d want %0d", k, issue_tag, k + 1); end
            tick();
        end
        drive_issue(4'd7, 5'd0, 32'd1, 5'd0, 32'd2);
        #1;
        total++; if (issue_ready !== 1'b0 || free_cnt !== 2'd0) begin
            bad++; $display("FAIL full_ready: got rdy=%b free=%0d want 0/0", issue_ready, free_cnt);
        end
        tick();
        idle();
        cdb_valid = 1; cdb_tag = 5'd9; cdb_data = 32'h55;
        #1;
        total++; if (busy_vec !== 3'b111 || disp_valid !== 1'b0) begin
            bad++; $display("FAIL full_ignore: got busy=%b dv=%b want 111/0", busy_vec, disp_valid);
        end
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (disp_valid !== 1'b1 || disp_tag !== 5'(k + 1) || disp_vj !== 32'h55 || disp_vk !== 32'(k + 10)) begin
                bad++; $display("FAIL capture_disp%0d: got v=%b tag=%0d vj=%0h vk=%0d want 1/%0d/55/%0d",
                                k, disp_valid, disp_tag, disp_vj, disp_vk, k + 1, k + 10);
            end
            tick();
        end
        total++; if (busy_vec !== 3'b000) begin bad++; $display("FAIL capture_drain: got %b want 000", busy_vec); end
    endtask

    task automatic test_issue_forward();
        disp_ready = 0;
        drive_issue(4'd3, 5'd0, 32'd1, 5'd4, 32'd0);
        cdb_valid = 1; cdb_tag = 5'd4; cdb_data = 32'hAB;
        tick();
        idle(); #1;
        total++; if (disp_valid !== 1'b1 || disp_vk !== 32'hAB || disp_tag !== 5'd1) begin
            bad++; $display("FAIL forward: got v=%b vk=%0h tag=%0d want 1/ab/1", disp_valid, disp_vk, disp_tag);
        end
        disp_ready = 1;
        tick();
    endtask

    task automatic test_back_to_back_stall();
        disp_ready = 0;
        drive_issue(4'd1, 5'd0, 32'h11, 5'd0, 32'h0);
        tick();
        drive_issue(4'd2, 5'd9, 32'h0, 5'd0, 32'h0);
        tick();
        drive_issue(4'd3, 5'd0, 32'h33, 5'd0, 32'h0);
        tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (disp_tag !== 5'd1 || busy_vec !== 3'b111) begin
                bad++; $display("FAIL stall%0d: got tag=%0d busy=%b want 1/111", k, disp_tag, busy_vec);
            end
            tick();
        end
        disp_ready = 1;
        tick();
        #1;
        total++; if (busy_vec !== 3'b110 || disp_tag !== 5'd3 || disp_vj !== 32'h33) begin
            bad++; $display("FAIL stall_next: got busy=%b tag=%0d vj=%0h want 110/3/33", busy_vec, disp_tag, disp_vj);
        end
        tick();
        total++; if (busy_vec !== 3'b010 || disp_valid !== 1'b0) begin
            bad++; $display("FAIL stall_drain: got busy=%b dv=%b want 010/0", busy_vec, disp_valid);
        end
    endtask

    task automatic test_flush_and_reset();
        disp_ready = 0;
        drive_issue(4'd4, 5'd0, 32'h1, 5'd0, 32'h2);
        tick();
        drive_issue(4'd5, 5'd0, 32'h3, 5'd0, 32'h4);
        tick();
        drive_issue(4'd6, 5'd0, 32'h5, 5'd0, 32'h6);
        disp_ready = 1; flush = 1;
        tick();
        idle(); disp_ready = 0; #1;
        total++; if (busy_vec !== 3'b000 || free_cnt !== 2'd3 || disp_valid !== 1'b0) begin
            bad++; $display("FAIL flush: got busy=%b free=%0d dv=%b want 000/3/0", busy_vec, free_cnt, disp_valid);
        end
        drive_issue(4'd8, 5'd0, 32'h77, 5'd0, 32'h88);
        tick();
        drive_issue(4'd9, 5'd3, 32'h0, 5'd0, 32'h0);
        tick();
        idle();
        #2;
        rst_n = 0; model_clear();
        #1;
        total++; if (busy_vec !== 3'b000 || free_cnt !== 2'd3 || issue_tag !== 5'd1 || issue_ready !== 1'b1) begin
            bad++; $display("FAIL async_reset: got busy=%b free=%0d tag=%0d rdy=%b want 000/3/1/1",
                            busy_vec, free_cnt, issue_tag, issue_ready);
        end
        total++; if (disp_valid !== 1'b0 || disp_vj !== 32'h0 || disp_op !== 4'h0) begin
            bad++; $display("FAIL async_reset_disp: got v=%b vj=%0h op=%0d want 0/0/0", disp_valid, disp_vj, disp_op);
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic bit [4:0] pick_tag();
        bit [4:0] t;
        case ($urandom_range(0, 5))
            0, 1: t = 5'd0;
            2: t = 5'd2;
            3: t = 5'd3;
            4: t = 5'd7;
            default: t = 5'd9;
        endcase
        return t;
    endfunction

    task automatic test_random();
        int rr;
        bit [4:0] e_tag;
        for (int c = 0; c < 500; c++) begin
            issue_valid = ($urandom_range(0, 9) < 6);
            issue_op    = 4'($urandom);
            issue_qj    = pick_tag();
            issue_vj    = $urandom;
            issue_qk    = pick_tag();
            issue_vk    = $urandom;
            cdb_valid   = $urandom_range(0, 1) == 1;
            cdb_tag     = pick_tag();
            cdb_data    = $urandom;
            disp_ready  = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 39) == 0);
            #1;
            rr    = first_ready();
            e_tag = (rr >= 0) ? 5'(rr + 1) : 5'd0;
            total++; if (busy_vec !== busy_bits() || free_cnt !== 2'(n_free())) begin
                bad++; $display("FAIL rand_busy c%0d: got busy=%b free=%0d want %b/%0d", c, busy_vec, free_cnt, busy_bits(), n_free());
            end
            total++; if (issue_ready !== (first_free() >= 0) || issue_tag !== ((first_free() >= 0) ? 5'(first_free() + 1) : 5'd1)) begin
                bad++; $display("FAIL rand_issue c%0d: got rdy=%b tag=%0d want ff=%0d", c, issue_ready, issue_tag, first_free());
            end
            total++; if (disp_valid !== (rr >= 0) || disp_tag !== e_tag) begin
                bad++; $display("FAIL rand_disp c%0d: got v=%b tag=%0d want v=%b tag=%0d", c, disp_valid, disp_tag, rr >= 0, e_tag);
            end
            if (rr >= 0) begin
                total++; if (disp_op !== m[rr].op || disp_vj !== m[rr].vj || disp_vk !== m[rr].vk) begin
                    bad++; $display("FAIL rand_ops c%0d: got op=%0d vj=%0h vk=%0h want %0d/%0h/%0h",
                                    c, disp_op, disp_vj, disp_vk, m[rr].op, m[rr].vj, m[rr].vk);
                end
            end else begin
                total++; if (disp_op !== 4'h0 || disp_vj !== 32'h0 || disp_vk !== 32'h0) begin
                    bad++; $display("FAIL rand_idle c%0d: got op=%0d vj=%0h vk=%0h want 0", c, disp_op, disp_vj, disp_vk);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_issue();
        test_fill_and_capture();
        test_issue_forward();
        test_back_to_back_stall();
        test_flush_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
